gmii_tx_scheduler: RTL and testbench

- Parametrised next-generation GMII transmit engine. Fetches frames from the TX slot RAM ring and emits preamble/SFD, payload, optional zero padding, FCS and a configurable inter-frame gap.
- Adds timestamp-gated launch against global_counter, length sanity checking with drop, and frame/drop statistics.
- Sits between the host-written TX slot RAM (producer advances mem_wr_ptr) and the GMII PHY pins.

---
 rtl/gmii_tx_pkg.sv | 45 ++++
 rtl/eth_crc32_d8.sv | 32 +++
 rtl/gmii_tx_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_gmii_tx_scheduler.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gmii_tx_pkg.sv
// Shared definitions for the GMII transmit scheduler.
//   tx_state_e     : scheduler FSM states
//   PREAMBLE_BYTE  : 0x55 preamble octet
//   SFD_BYTE       : 0xD5 start-of-frame delimiter
//   HDR_WORDS      : 16-bit slot header words ahead of the payload (len, ts x4, hash x2)
//   CRC32_*        : Ethernet CRC-32 constants (normal-form polynomial and residue)
//   crc32_byte()   : one reflected CRC-32 byte step
package gmii_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_WAIT_TS,
    ST_PRE,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } tx_state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam int unsigned HDR_WORDS     = 7;

  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

  // Reflected (LSB-first) update: the register holds the CRC bit-reversed,
  // so the polynomial is applied in its bit-reversed form.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    logic [31:0] rpoly;
    c = crc;
    for (int unsigned i = 0; i < 32; i++) begin
      rpoly[i] = CRC32_POLY[31-i];
    end
    for (int unsigned i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ rpoly;
      else             c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// Byte-wide Ethernet CRC-32 accumulator.
//   clk_i      : clock
//   rst_i      : synchronous active-high reset (loads the init value)
//   init_i     : reload the init value
//   data_en_i  : fold data_i into the running CRC
//   data_i     : byte to accumulate
//   crc_o      : complemented CRC, octet k (k=0 transmitted first) in bits [8k+7:8k]
module eth_crc32_d8
  import gmii_tx_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        init_i,
  input  logic        data_en_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] crc_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || init_i) begin
      crc_q <= CRC32_INIT;
    end else if (data_en_i) begin
      crc_q <= crc32_byte(crc_q, data_i);
    end
  end

  // Reflected register: the low octet is already the first FCS octet on the wire.
  assign crc_o = ~crc_q;

endmodule

// File: rtl/gmii_tx_scheduler.sv
// GMII transmit engine fed from a 16-bit slot RAM ring.
//   gmii_tx_clk       : sole clock
//   sys_rst           : synchronous active-high reset
//   global_counter    : time base for timestamp-gated launch
//   tx_enable         : allow new frames to start
//   ts_gate_en        : honour the header timestamp
//   gmii_txd/_tx_en   : GMII transmit pins (registered)
//   slot_tx_eth_addr  : RAM word address (read data one cycle later on slot_tx_eth_q)
//   mem_wr_ptr        : producer pointer; mem_rd_ptr : first word of next unsent frame
//   frame_count       : frames sent (wraps); drop_count : bad-length drops (saturates)
//   busy              : FSM not idle
module gmii_tx_scheduler
  import gmii_tx_pkg::*;
#(
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned IFG_BYTES = 12,
  parameter int unsigned PAD_EN    = 1,
  parameter int unsigned MIN_LEN   = 60,
  parameter int unsigned MAX_LEN   = 1518
) (
  input  logic              gmii_tx_clk,
  input  logic              sys_rst,
  input  logic [63:0]       global_counter,
  input  logic              tx_enable,
  input  logic              ts_gate_en,
  output logic [7:0]        gmii_txd,
  output logic              gmii_tx_en,
  output logic [ADDR_W-1:0] slot_tx_eth_addr,
  input  logic [15:0]       slot_tx_eth_q,
  input  logic [ADDR_W-1:0] mem_wr_ptr,
  output logic [ADDR_W-1:0] mem_rd_ptr,
  output logic [31:0]       frame_count,
  output logic [15:0]       drop_count,
  output logic              busy
);

  tx_state_e         state_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W-1:0] mem_rd_ptr_q;
  logic [15:0]       len_q;
  logic [15:0]       cnt_q;
  logic [15:0]       word_q;
  logic [63:0]       ts_q;
  logic [7:0]        txd_q;
  logic              tx_en_q;
  logic [31:0]       frame_count_q;
  logic [15:0]       drop_count_q;

  logic              len_bad_d;
  logic              ts_ok_d;
  logic              need_pad_d;
  logic [15:0]       pad_last_d;
  logic [7:0]        data_byte_d;
  logic              crc_init_d;
  logic              crc_en_d;
  logic [7:0]        crc_data_d;
  logic [31:0]       crc_d;
  logic [7:0]        crc_byte_d;
  logic [16:0]       len_words_d;
  logic [ADDR_W-1:0] next_start_d;

  always_comb begin
    len_bad_d    = (len_q == '0) || (len_q > 16'(MAX_LEN));
    ts_ok_d      = !ts_gate_en || (ts_q == '0) || (global_counter >= ts_q);
    need_pad_d   = (PAD_EN != 0) && (len_q < 16'(MIN_LEN));
    pad_last_d   = 16'(MIN_LEN) - len_q - 16'd1;
    // Even byte index -> high byte of the held word, odd -> low byte.
    data_byte_d  = cnt_q[0] ? word_q[7:0] : word_q[15:8];
    crc_init_d   = (state_q == ST_PRE);
    crc_en_d     = (state_q == ST_DATA) || (state_q == ST_PAD);
    crc_data_d   = (state_q == ST_PAD) ? '0 : data_byte_d;
    crc_byte_d   = crc_d[{cnt_q[1:0], 3'b000} +: 8];
    len_words_d  = ({1'b0, len_q} + 17'd1) >> 1;
    next_start_d = mem_rd_ptr_q + ADDR_W'(HDR_WORDS) + ADDR_W'(len_words_d);
  end

  eth_crc32_d8 u_crc (
    .clk_i     (gmii_tx_clk),
    .rst_i     (sys_rst),
    .init_i    (crc_init_d),
    .data_en_i (crc_en_d),
    .data_i    (crc_data_d),
    .crc_o     (crc_d)
  );

  always_ff @(posedge gmii_tx_clk) begin
    if (sys_rst) begin
      state_q       <= ST_IDLE;
      rd_ptr_q      <= '0;
      mem_rd_ptr_q  <= '0;
      len_q         <= '0;
      cnt_q         <= '0;
      word_q        <= '0;
      ts_q          <= '0;
      txd_q         <= '0;
      tx_en_q       <= 1'b0;
      frame_count_q <= '0;
      drop_count_q  <= '0;
    end else begin
      txd_q   <= '0;
      tx_en_q <= 1'b0;
      cnt_q   <= cnt_q + 16'd1;
      unique case (state_q)
        ST_IDLE: begin
          rd_ptr_q <= mem_rd_ptr_q;
          cnt_q    <= '0;
          if (tx_enable && (mem_rd_ptr_q != mem_wr_ptr)) state_q <= ST_HDR;
        end
        // Address runs one word ahead of the sampled data: at count c the RAM
        // returns header word c-1. The address stops on the first payload word.
        ST_HDR: begin
          if (cnt_q < 16'(HDR_WORDS)) rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
          case (cnt_q)
            16'd1:                      len_q <= slot_tx_eth_q;
            16'd2, 16'd3, 16'd4, 16'd5: ts_q  <= {ts_q[47:0], slot_tx_eth_q};
            default: ;
          endcase
          if (cnt_q == 16'(HDR_WORDS)) begin
            cnt_q <= '0;
            if (len_bad_d) begin
              state_q      <= ST_IDLE;
              mem_rd_ptr_q <= mem_wr_ptr;
              rd_ptr_q     <= mem_wr_ptr;
              if (drop_count_q != '1) drop_count_q <= drop_count_q + 16'd1;
            end else begin
              state_q <= ST_WAIT_TS;
            end
          end
        end
        ST_WAIT_TS: begin
          cnt_q <= '0;
          if (ts_ok_d) begin
            word_q   <= slot_tx_eth_q;
            rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            state_q  <= ST_PRE;
          end
        end
        ST_PRE: begin
          tx_en_q <= 1'b1;
          txd_q   <= (cnt_q == 16'd7) ? SFD_BYTE : PREAMBLE_BYTE;
          if (cnt_q == 16'd7) begin
            cnt_q   <= '0;
            state_q <= ST_DATA;
          end
        end
        // Two cycles per word gives the RAM its read latency for free.
        ST_DATA: begin
          tx_en_q <= 1'b1;
          txd_q   <= data_byte_d;
          if (cnt_q[0]) begin
            word_q   <= slot_tx_eth_q;
            rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
          end
          if (cnt_q == len_q - 16'd1) begin
            cnt_q   <= '0;
            state_q <= need_pad_d ? ST_PAD : ST_FCS;
          end
        end
        ST_PAD: begin
          tx_en_q <= 1'b1;
          if (cnt_q == pad_last_d) begin
            cnt_q   <= '0;
            state_q <= ST_FCS;
          end
        end
        ST_FCS: begin
          tx_en_q <= 1'b1;
          txd_q   <= crc_byte_d;
          if (cnt_q == 16'd3) begin
            cnt_q   <= '0;
            state_q <= ST_IFG;
          end
        end
        ST_IFG: begin
          if (cnt_q == 16'(IFG_BYTES - 1)) begin
            cnt_q         <= '0;
            mem_rd_ptr_q  <= next_start_d;
            rd_ptr_q      <= next_start_d;
            frame_count_q <= frame_count_q + 32'd1;
            state_q       <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gmii_txd         = txd_q;
  assign gmii_tx_en       = tx_en_q;
  assign slot_tx_eth_addr = rd_ptr_q;
  assign mem_rd_ptr       = mem_rd_ptr_q;
  assign frame_count      = frame_count_q;
  assign drop_count       = drop_count_q;
  assign busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_gmii_tx_scheduler.sv
module tb_gmii_tx_scheduler;
  import gmii_tx_pkg::*;

  localparam int IFG0 = 12;
  localparam int IFG1 = 4;
  localparam int MIN0 = 60;
  localparam int SZ0  = 64;
  localparam int SZ1  = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] gc = '0;
  logic        gc_load;
  logic [63:0] gc_val;
  logic        tsg;

  logic        en0, txen0, busy0;
  logic [7:0]  txd0;
  logic [5:0]  addr0, wr0, rd0;
  logic [15:0] q0, dc0;
  logic [31:0] fc0;

  logic        en1, txen1, busy1;
  logic [7:0]  txd1;
  logic [7:0]  addr1, wr1, rd1;
  logic [15:0] q1, dc1;
  logic [31:0] fc1;

  logic [15:0] mem0 [SZ0];
  logic [15:0] mem1 [SZ1];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (gc_load) gc <= gc_val;
    else         gc <= gc + 64'd1;
    q0 <= mem0[addr0];
    q1 <= mem1[addr1];
  end

  gmii_tx_scheduler #(.ADDR_W(6), .IFG_BYTES(IFG0), .PAD_EN(1), .MIN_LEN(MIN0), .MAX_LEN(1518)) u0 (
    .gmii_tx_clk(clk), .sys_rst(rst), .global_counter(gc), .tx_enable(en0), .ts_gate_en(tsg),
    .gmii_txd(txd0), .gmii_tx_en(txen0), .slot_tx_eth_addr(addr0), .slot_tx_eth_q(q0),
    .mem_wr_ptr(wr0), .mem_rd_ptr(rd0), .frame_count(fc0), .drop_count(dc0), .busy(busy0));

  gmii_tx_scheduler #(.ADDR_W(8), .IFG_BYTES(IFG1), .PAD_EN(0), .MIN_LEN(60), .MAX_LEN(1518)) u1 (
    .gmii_tx_clk(clk), .sys_rst(rst), .global_counter(gc), .tx_enable(en1), .ts_gate_en(1'b0),
    .gmii_txd(txd1), .gmii_tx_en(txen1), .slot_tx_eth_addr(addr1), .slot_tx_eth_q(q1),
    .mem_wr_ptr(wr1), .mem_rd_ptr(rd1), .frame_count(fc1), .drop_count(dc1), .busy(busy1));

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] pl_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  logic [7:0] got_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic logic en_of(input int inst);
    return (inst == 0) ? txen0 : txen1;
  endfunction

  function automatic logic [7:0] txd_of(input int inst);
    return (inst == 0) ? txd0 : txd1;
  endfunction

  function automatic logic busy_of(input int inst);
    return (inst == 0) ? busy0 : busy1;
  endfunction

  function automatic int next_ptr(input int p, input int len, input int sz);
    return (p + 7 + (len + 1) / 2) % sz;
  endfunction

  task automatic make_payload(input int len);
    pl_q = {};
    repeat (len) pl_q.push_back(8'($urandom));
  endtask

  // Writes header + payload words (header only when pl_q is empty).
  task automatic load_frame(input int inst, input int start, input int len, input logic [63:0] ts);
    logic [15:0] w[$];
    logic [7:0]  hi, lo;
    int sz;
    sz = (inst == 0) ? SZ0 : SZ1;
    w.push_back(16'(len));
    for (int k = 3; k >= 0; k--) w.push_back(ts[16*k +: 16]);
    w.push_back(16'($urandom));
    w.push_back(16'($urandom));
    for (int i = 0; i < (pl_q.size() + 1) / 2; i++) begin
      hi = pl_q[2*i];
      lo = (2*i + 1 < pl_q.size()) ? pl_q[2*i+1] : 8'hEE;
      w.push_back({hi, lo});
    end
    foreach (w[i]) begin
      if (inst == 0) mem0[(start + i) % sz] = w[i];
      else           mem1[(start + i) % sz] = w[i];
    end
  endtask

  // Wire image of a frame: preamble/SFD, payload, zero pad, FCS LSB octet first.
  task automatic build_expected(input bit pad_en);
    logic [7:0]  body[$];
    logic [31:0] c;
    body = pl_q;
    if (pad_en) while (body.size() < MIN0) body.push_back(8'h00);
    exp_q = {};
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    c = 32'hFFFFFFFF;
    foreach (body[i]) begin
      exp_q.push_back(body[i]);
      c = crc_step(c, body[i]);
    end
    c = ~c;
    for (int k = 0; k < 4; k++) exp_q.push_back(c[8*k +: 8]);
  endtask

  // Collects one tx_en-high burst; low = tx_en-low samples before it.
  task automatic capture(input int inst, output int low, output logic [63:0] rise_gc);
    bit seen;
    seen = 0;
    low = 0;
    rise_gc = '0;
    got_q = {};
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (en_of(inst)) begin
        if (!seen) rise_gc = gc;
        seen = 1;
        got_q.push_back(txd_of(inst));
      end else if (seen) begin
        break;
      end else begin
        low++;
      end
    end
    check("frame observed", 64'(seen), 64'd1);
  endtask

  task automatic compare_frame(input string tag);
    int n;
    check({tag, " length"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s byte %0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
      if (got_q[i] !== exp_q[i]) break;
    end
  endtask

  task automatic wait_idle(input int inst, input string tag);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy_of(inst)) break;
    end
    check({tag, " idle"}, 64'(busy_of(inst)), 64'd0);
  endtask

  initial begin
    int p0, p1, low, low2, highs;
    logic [63:0] rg;
    logic [31:0] c, r;

    rst = 1'b1; en0 = 1'b0; en1 = 1'b0; tsg = 1'b0;
    gc_load = 1'b0; gc_val = '0; wr0 = '0; wr1 = '0;
    p0 = 0; p1 = 0;
    repeat (3) @(negedge clk);
    check("rst tx_en", 64'(txen0), 64'd0);
    check("rst txd", 64'(txd0), 64'd0);
    check("rst rd_ptr", 64'(rd0), 64'd0);
    check("rst addr", 64'(addr0), 64'd0);
    check("rst frame_count", 64'(fc0), 64'd0);
    check("rst drop_count", 64'(dc0), 64'd0);
    check("rst busy", 64'(busy0), 64'd0);
    rst = 1'b0; en0 = 1'b1; en1 = 1'b1;
    @(negedge clk);

    // Known-answer frame, no padding: "123456789" has CRC-32 0xCBF43926.
    pl_q = {};
    for (int i = 0; i < 9; i++) pl_q.push_back(8'(8'h31 + i));
    load_frame(1, p1, 9, 64'd0);
    build_expected(1'b0);
    p1 = next_ptr(p1, 9, SZ1);
    wr1 = 8'(p1);
    capture(1, low, rg);
    check("start latency", 64'(low), 64'd10);
    compare_frame("kat");
    check("kat fcs", {32'h0, got_q[got_q.size()-4], got_q[got_q.size()-3],
                      got_q[got_q.size()-2], got_q[got_q.size()-1]}, 64'h2639F4CB);
    wait_idle(1, "kat");
    check("kat rd_ptr", 64'(rd1), 64'd12);
    check("kat frame_count", 64'(fc1), 64'd1);

    // Back-to-back, IFG 4. Between frames tx_en is low for the IFG plus the
    // next frame's IDLE/header/launch cycles (10).
    make_payload(30); load_frame(1, p1, 30, 64'd0); build_expected(1'b0); exp_a = exp_q;
    p1 = next_ptr(p1, 30, SZ1);
    make_payload(17); load_frame(1, p1, 17, 64'd0); build_expected(1'b0); exp_b = exp_q;
    p1 = next_ptr(p1, 17, SZ1);
    wr1 = 8'(p1);
    capture(1, low, rg);
    exp_q = exp_a; compare_frame("b2b1 f1");
    capture(1, low2, rg);
    check("ifg4 gap", 64'(low2 + 1), 64'(IFG1 + 10));
    check("ifg4 gap>=IFG", 64'(low2 + 1 >= IFG1), 64'd1);
    exp_q = exp_b; compare_frame("b2b1 f2");
    wait_idle(1, "b2b1");
    check("b2b1 rd_ptr", 64'(rd1), 64'(p1));
    check("b2b1 frame_count", 64'(fc1), 64'd3);

    // Short frame padded to 60 bytes.
    make_payload(20); load_frame(0, p0, 20, 64'd0); build_expected(1'b1);
    p0 = next_ptr(p0, 20, SZ0);
    wr0 = 6'(p0);
    capture(0, low, rg);
    compare_frame("pad");
    check("pad bytes after SFD", 64'(got_q.size() - 8), 64'(MIN0 + 4));
    c = 32'hFFFFFFFF;
    for (int i = 8; i < got_q.size(); i++) c = crc_step(c, got_q[i]);
    for (int k = 0; k < 32; k++) r[k] = c[31-k];
    check("pad residue", 64'(r), 64'(CRC32_RESIDUE));
    wait_idle(0, "pad");
    check("pad rd_ptr", 64'(rd0), 64'(p0));
    check("pad frame_count", 64'(fc0), 64'd1);

    // Back-to-back, IFG 12.
    make_payload(11); load_frame(0, p0, 11, 64'd0); build_expected(1'b1); exp_a = exp_q;
    p0 = next_ptr(p0, 11, SZ0);
    make_payload(24); load_frame(0, p0, 24, 64'd0); build_expected(1'b1); exp_b = exp_q;
    p0 = next_ptr(p0, 24, SZ0);
    wr0 = 6'(p0);
    capture(0, low, rg);
    exp_q = exp_a; compare_frame("b2b0 f1");
    capture(0, low2, rg);
    check("ifg12 gap", 64'(low2 + 1), 64'(IFG0 + 10));
    exp_q = exp_b; compare_frame("b2b0 f2");
    wait_idle(0, "b2b0");
    check("b2b0 rd_ptr", 64'(rd0), 64'(p0));

    // Frame straddling ring word 63 -> 0 (starts at 49, 27 words).
    make_payload(40); load_frame(0, p0, 40, 64'd0); build_expected(1'b1);
    p0 = next_ptr(p0, 40, SZ0);
    wr0 = 6'(p0);
    capture(0, low, rg);
    compare_frame("wrap");
    wait_idle(0, "wrap");
    check("wrap rd_ptr", 64'(rd0), 64'd12);
    check("wrap frame_count", 64'(fc0), 64'd4);

    // Timestamp gating: counter at 900, launch at 1000. The engine leaves
    // WAIT_TS on the edge that samples 1000 and tx_en follows one edge later.
    tsg = 1'b1;
    gc_load = 1'b1; gc_val = 64'd900;
    @(negedge clk);
    gc_load = 1'b0;
    make_payload(14); load_frame(0, p0, 14, 64'd1000); build_expected(1'b1);
    p0 = next_ptr(p0, 14, SZ0);
    wr0 = 6'(p0);
    capture(0, low, rg);
    check("gate launch time", rg, 64'd1002);
    compare_frame("gate");
    wait_idle(0, "gate");

    make_payload(10); load_frame(0, p0, 10, 64'd500); build_expected(1'b1);
    p0 = next_ptr(p0, 10, SZ0);
    wr0 = 6'(p0);
    capture(0, low, rg);
    check("past ts latency", 64'(low), 64'd10);
    compare_frame("past ts");
    wait_idle(0, "past ts");
    check("gate frame_count", 64'(fc0), 64'd6);
    tsg = 1'b0;

    // Bad lengths: dropped, ring flushed to mem_wr_ptr, nothing transmitted.
    pl_q = {};
    load_frame(0, p0, 0, 64'd0);
    p0 = (p0 + 12) % SZ0;
    wr0 = 6'(p0);
    highs = 0;
    repeat (30) begin @(negedge clk); if (txen0) highs++; end
    check("len0 no tx", 64'(highs), 64'd0);
    check("len0 drop_count", 64'(dc0), 64'd1);
    check("len0 rd_ptr", 64'(rd0), 64'(p0));
    load_frame(0, p0, 2000, 64'd0);
    p0 = (p0 + 10) % SZ0;
    wr0 = 6'(p0);
    highs = 0;
    repeat (30) begin @(negedge clk); if (txen0) highs++; end
    check("len2000 no tx", 64'(highs), 64'd0);
    check("len2000 drop_count", 64'(dc0), 64'd2);
    check("len2000 rd_ptr", 64'(rd0), 64'(p0));
    check("drop frame_count", 64'(fc0), 64'd6);
    check("drop busy", 64'(busy0), 64'd0);

    // Reset in the middle of DATA.
    make_payload(50); load_frame(0, p0, 50, 64'd0);
    p0 = next_ptr(p0, 50, SZ0);
    wr0 = 6'(p0);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (txen0) break;
    end
    check("pre-reset tx_en", 64'(txen0), 64'd1);
    repeat (12) @(negedge clk);
    rst = 1'b1; wr0 = '0; wr1 = '0;
    @(posedge clk); #1;
    check("mid rst tx_en", 64'(txen0), 64'd0);
    check("mid rst txd", 64'(txd0), 64'd0);
    check("mid rst frame_count", 64'(fc0), 64'd0);
    check("mid rst drop_count", 64'(dc0), 64'd0);
    check("mid rst rd_ptr", 64'(rd0), 64'd0);
    check("mid rst busy", 64'(busy0), 64'd0);
    check("mid rst u1 frame_count", 64'(fc1), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
